// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Two-requester arbiter and access sequencer placed in front of the
// byte-addressed data memory. Port 0 is the core load/store unit and port 1
// is the debug/DMA loader. Requests are granted round-robin. Each request is
// checked for size, alignment and address range, and then one memory transfer
// runs at a time. The sequencer waits on mem_rdy, bounded by a timeout, and
// returns a one-cycle response pulse to the port that owns the transfer.
//
// Parameters
//   MEM_BYTES : memory size in bytes; an access is legal only when
//               addr + size <= MEM_BYTES
//   TIMEOUT   : maximum number of ACCESS cycles spent waiting for mem_rdy
//               (must be >= 1)
//
// Ports
//   clk, rst_n           : rising-edge clock, asynchronous active-low reset
//   pN_req/addr/we/      : request from port N (N = 0, 1); the request is
//   wdata/size             held stable until pN_gnt
//   pN_gnt               : combinational; the request is accepted this cycle
//   pN_rvalid            : one-cycle response pulse
//   pN_rdata             : zero-extended load data (0 for stores and errors)
//   pN_err               : valid with pN_rvalid; the access was rejected or
//                          timed out
//   mem_*                : memory interface; driven only in ACCESS, 0 otherwise
//   mem_read_data        : combinational read data from the memory
//   mem_rdy              : the access completes on a rising edge where it is 1
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int unsigned MEM_BYTES = 64,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        p0_req,
  input  logic [31:0] p0_addr,
  input  logic        p0_we,
  input  logic [31:0] p0_wdata,
  input  logic [2:0]  p0_size,
  output logic        p0_gnt,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  output logic        p0_err,

  input  logic        p1_req,
  input  logic [31:0] p1_addr,
  input  logic        p1_we,
  input  logic [31:0] p1_wdata,
  input  logic [2:0]  p1_size,
  output logic        p1_gnt,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic        p1_err,

  output logic [31:0] mem_address,
  output logic        mem_write_enable,
  output logic        mem_read_enable,
  output logic [31:0] mem_write_data,
  output logic [2:0]  mem_xfer_size,
  input  logic [31:0] mem_read_data,
  input  logic        mem_rdy
);

  // The counter must be wide enough to hold TIMEOUT-1. It is kept at least
  // one bit wide so that TIMEOUT = 1 still elaborates.
  localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Legality and load-data helpers
  // ---------------------------------------------------------------------------
  function automatic logic access_legal(input logic [31:0] a, input logic [2:0] s);
    logic        size_ok;
    logic        align_ok;
    logic [32:0] end_addr;
    size_ok  = (s == 3'd1) || (s == 3'd2) || (s == 3'd4);
    align_ok = (s == 3'd2) ? ~a[0] :
               (s == 3'd4) ? (a[1:0] == 2'b00) : 1'b1;
    // The end address is computed in 33 bits so that an address near
    // 2^32 cannot wrap around into the legal range.
    end_addr = {1'b0, a} + {30'd0, s};
    return size_ok && align_ok && (end_addr <= 33'(MEM_BYTES));
  endfunction

  function automatic logic [31:0] mask_load(input logic [31:0] d, input logic [2:0] s);
    case (s)
      3'd1:    return {24'd0, d[7:0]};
      3'd2:    return {16'd0, d[15:0]};
      default: return d;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Per-port inputs collected into arrays so that the logic below can be
  // indexed by port number
  // ---------------------------------------------------------------------------
  logic [1:0]  req;
  logic [31:0] req_addr  [2];
  logic        req_we    [2];
  logic [31:0] req_wdata [2];
  logic [2:0]  req_size  [2];

  assign req          = {p1_req, p0_req};
  assign req_addr[0]  = p0_addr;
  assign req_addr[1]  = p1_addr;
  assign req_we[0]    = p0_we;
  assign req_we[1]    = p1_we;
  assign req_wdata[0] = p0_wdata;
  assign req_wdata[1] = p1_wdata;
  assign req_size[0]  = p0_size;
  assign req_size[1]  = p1_size;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e          state_q,      state_d;
  logic            last_grant_q, last_grant_d;
  logic            owner_q,      owner_d;
  logic [31:0]     addr_q,       addr_d;
  logic            we_q,         we_d;
  logic [31:0]     wdata_q,      wdata_d;
  logic [2:0]      size_q,       size_d;
  logic [CW-1:0]   cnt_q,        cnt_d;
  logic [31:0]     rdata_q,      rdata_d;
  logic            err_q,        err_d;

  // ---------------------------------------------------------------------------
  // Arbitration. Grants are issued only in IDLE. When both ports request,
  // the port that was not granted last wins.
  // ---------------------------------------------------------------------------
  logic win_valid;
  logic winner;

  always_comb begin
    win_valid = 1'b0;
    winner    = 1'b0;
    if (state_q == ST_IDLE) begin
      unique case (req)
        2'b01: begin win_valid = 1'b1; winner = 1'b0;          end
        2'b10: begin win_valid = 1'b1; winner = 1'b1;          end
        2'b11: begin win_valid = 1'b1; winner = ~last_grant_q; end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    size_d       = size_q;
    cnt_d        = cnt_q;
    rdata_d      = rdata_q;
    err_d        = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (win_valid) begin
          owner_d      = winner;
          last_grant_d = winner;
          addr_d       = req_addr[winner];
          we_d         = req_we[winner];
          wdata_d      = req_wdata[winner];
          size_d       = req_size[winner];
          if (access_legal(req_addr[winner], req_size[winner])) begin
            state_d = ST_ACCESS;
            cnt_d   = '0;
          end else begin
            // An illegal request is answered straight away. The memory is
            // never enabled for it.
            state_d = ST_RESP;
            err_d   = 1'b1;
            rdata_d = '0;
          end
        end
      end

      ST_ACCESS: begin
        if (mem_rdy) begin
          state_d = ST_RESP;
          err_d   = 1'b0;
          rdata_d = we_q ? 32'd0 : mask_load(mem_read_data, size_q);
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = ST_RESP;
          err_d   = 1'b1;
          rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_RESP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers. last_grant resets to 1 so that port 0 wins the first
  // contested arbitration.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      size_q       <= '0;
      cnt_q        <= '0;
      rdata_q      <= '0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      owner_q      <= owner_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      size_q       <= size_d;
      cnt_q        <= cnt_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Memory interface. The outputs are decoded from the state register, so the
  // asynchronous reset drops them at once and abandons any transfer in flight.
  // ---------------------------------------------------------------------------
  logic in_access;
  assign in_access        = (state_q == ST_ACCESS);
  assign mem_address      = in_access ? addr_q  : 32'd0;
  assign mem_write_data   = in_access ? wdata_q : 32'd0;
  assign mem_xfer_size    = in_access ? size_q  : 3'd0;
  assign mem_write_enable = in_access &  we_q;
  assign mem_read_enable  = in_access & ~we_q;

  // ---------------------------------------------------------------------------
  // Per-port grant and response outputs
  // ---------------------------------------------------------------------------
  logic [1:0]  gnt;
  logic [1:0]  rvalid;
  logic [1:0]  err_out;
  logic [31:0] rdata_out [2];

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign gnt[gi]       = win_valid && (winner == 1'(gi));
    assign rvalid[gi]    = (state_q == ST_RESP) && (owner_q == 1'(gi));
    assign err_out[gi]   = rvalid[gi] & err_q;
    assign rdata_out[gi] = rvalid[gi] ? rdata_q : 32'd0;
  end

  assign p0_gnt    = gnt[0];
  assign p1_gnt    = gnt[1];
  assign p0_rvalid = rvalid[0];
  assign p1_rvalid = rvalid[1];
  assign p0_err    = err_out[0];
  assign p1_err    = err_out[1];
  assign p0_rdata  = rdata_out[0];
  assign p1_rdata  = rdata_out[1];

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

  localparam int MEM_BYTES = 64;
  localparam int TIMEOUT   = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_req, p0_we, p0_gnt, p0_rvalid, p0_err;
  logic [31:0] p0_addr, p0_wdata, p0_rdata;
  logic [2:0]  p0_size;
  logic        p1_req, p1_we, p1_gnt, p1_rvalid, p1_err;
  logic [31:0] p1_addr, p1_wdata, p1_rdata;
  logic [2:0]  p1_size;
  logic [31:0] mem_address, mem_write_data, mem_read_data;
  logic        mem_write_enable, mem_read_enable, mem_rdy;
  logic [2:0]  mem_xfer_size;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.MEM_BYTES(MEM_BYTES), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_we(p0_we), .p0_wdata(p0_wdata),
    .p0_size(p0_size), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid),
    .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_addr(p1_addr), .p1_we(p1_we), .p1_wdata(p1_wdata),
    .p1_size(p1_size), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid),
    .p1_rdata(p1_rdata), .p1_err(p1_err),
    .mem_address(mem_address), .mem_write_enable(mem_write_enable),
    .mem_read_enable(mem_read_enable), .mem_write_data(mem_write_data),
    .mem_xfer_size(mem_xfer_size), .mem_read_data(mem_read_data),
    .mem_rdy(mem_rdy)
  );

  // ---------------- memory model (the "real" memory) ----------------
  logic [7:0] mem [MEM_BYTES];
  logic       mem_init;

  function automatic logic [7:0] pattern(input int i);
    return 8'((i * 29 + 7) & 255);
  endfunction

  always_comb begin
    mem_read_data = '0;
    for (int k = 0; k < 4; k++)
      mem_read_data[8*k +: 8] = mem[(int'(mem_address[5:0]) + k) % MEM_BYTES];
  end

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < MEM_BYTES; i++) mem[i] <= pattern(i);
    end else if (mem_write_enable && mem_rdy) begin
      for (int k = 0; k < int'(mem_xfer_size) && k < 4; k++)
        mem[(int'(mem_address[5:0]) + k) % MEM_BYTES] <= mem_write_data[8*k +: 8];
    end
  end

  // ---------------- reference model ----------------
  byte unsigned ref_mem [MEM_BYTES];
  int           ref_last;   // port granted most recently

  function automatic bit ref_legal(input longint addr, input int size);
    if (!(size == 1 || size == 2 || size == 4)) return 1'b0;
    if (addr % size != 0) return 1'b0;
    return (addr + size) <= MEM_BYTES;
  endfunction

  function automatic logic [31:0] ref_load(input longint addr, input int size);
    logic [31:0] v;
    v = 0;
    for (int k = 0; k < size; k++) v = v | (32'(ref_mem[addr + k]) << (8 * k));
    return v;
  endfunction

  // ---------------- checking ----------------
  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask

  // ---------------- per-port access helpers ----------------
  task automatic set_req(input int port, input logic r, input logic [31:0] a,
                         input logic w, input logic [31:0] d, input logic [2:0] s);
    if (port == 0) begin
      p0_req = r; p0_addr = a; p0_we = w; p0_wdata = d; p0_size = s;
    end else begin
      p1_req = r; p1_addr = a; p1_we = w; p1_wdata = d; p1_size = s;
    end
  endtask

  function automatic logic get_gnt(input int port);
    return (port == 0) ? p0_gnt : p1_gnt;
  endfunction
  function automatic logic get_rvalid(input int port);
    return (port == 0) ? p0_rvalid : p1_rvalid;
  endfunction
  function automatic logic get_err(input int port);
    return (port == 0) ? p0_err : p1_err;
  endfunction
  function automatic logic [31:0] get_rdata(input int port);
    return (port == 0) ? p0_rdata : p1_rdata;
  endfunction

  // One single-port transaction. Entered and left at posedge+1 with the DUT
  // idle. rdy_delay = number of ACCESS cycles with mem_rdy low before it rises.
  task automatic run_single(input int port, input logic [31:0] addr, input logic we,
                            input logic [31:0] wdata, input logic [2:0] size,
                            input int rdy_delay);
    bit          legal, exp_err;
    int          exp_resp, exp_en, resp_cyc, we_cnt, re_cnt, other_rv;
    logic [31:0] exp_rdata;

    legal     = ref_legal(longint'(addr), int'(size));
    exp_err   = !legal || (rdy_delay >= TIMEOUT);
    exp_resp  = !legal ? 1 : ((rdy_delay < TIMEOUT) ? rdy_delay + 2 : TIMEOUT + 1);
    exp_en    = legal ? exp_resp - 1 : 0;
    exp_rdata = (exp_err || we) ? 32'd0 : ref_load(longint'(addr), int'(size));

    set_req(port, 1'b1, addr, we, wdata, size);
    set_req(1 - port, 1'b0, 32'd0, 1'b0, 32'd0, 3'd0);
    mem_rdy = 1'b0;
    @(negedge clk);
    check_eq("gnt_owner", 32'(get_gnt(port)), 32'd1);
    check_eq("gnt_other", 32'(get_gnt(1 - port)), 32'd0);
    ref_last = port;
    @(posedge clk); #1;
    set_req(port, 1'b0, addr, we, wdata, size);

    resp_cyc = -1; we_cnt = 0; re_cnt = 0; other_rv = 0;
    for (int cyc = 1; cyc <= TIMEOUT + 8 && resp_cyc < 0; cyc++) begin
      mem_rdy = (cyc > rdy_delay);
      @(negedge clk);
      if (mem_write_enable) we_cnt++;
      if (mem_read_enable)  re_cnt++;
      if (get_rvalid(1 - port)) other_rv++;
      if (cyc == 1 && legal) begin
        check_eq("mem_address", mem_address, addr);
        check_eq("mem_xfer_size", 32'(mem_xfer_size), 32'(size));
        if (we) check_eq("mem_write_data", mem_write_data, wdata);
      end
      if (get_rvalid(port)) begin
        resp_cyc = cyc;
        check_eq("rdata", get_rdata(port), exp_rdata);
        check_eq("err", 32'(get_err(port)), 32'(exp_err));
      end else begin
        @(posedge clk); #1;
      end
    end
    check_eq("resp_latency", 32'(resp_cyc), 32'(exp_resp));
    check_eq("mem_we_cycles", 32'(we_cnt), we ? 32'(exp_en) : 32'd0);
    check_eq("mem_re_cycles", 32'(re_cnt), we ? 32'd0 : 32'(exp_en));
    check_eq("other_rvalid", 32'(other_rv), 32'd0);

    @(posedge clk); #1;
    mem_rdy = 1'b0;
    @(negedge clk);
    check_eq("rvalid_pulse", 32'(get_rvalid(port)), 32'd0);
    @(posedge clk); #1;

    if (!exp_err && we)
      for (int k = 0; k < int'(size); k++) ref_mem[addr + k] = wdata[8*k +: 8];
    $display("txn p%0d addr=%08h size=%0d we=%0b rdy_delay=%0d -> resp@%0d err=%0b rdata=%08h",
             port, addr, size, we, rdy_delay, resp_cyc, exp_err, exp_rdata);
  endtask

  // Both ports hold load requests; grants must follow the round-robin order.
  task automatic run_contested(input int n);
    int          win;
    logic [31:0] a [2];
    logic [2:0]  s [2];
    a[0] = 32'h10; s[0] = 3'd1;
    a[1] = 32'h20; s[1] = 3'd4;
    set_req(0, 1'b1, a[0], 1'b0, 32'd0, s[0]);
    set_req(1, 1'b1, a[1], 1'b0, 32'd0, s[1]);
    mem_rdy = 1'b1;
    for (int t = 0; t < n; t++) begin
      win = (ref_last == 0) ? 1 : 0;
      @(negedge clk);
      check_eq("rr_gnt0", 32'(p0_gnt), 32'(win == 0));
      check_eq("rr_gnt1", 32'(p1_gnt), 32'(win == 1));
      ref_last = win;
      @(negedge clk);
      check_eq("rr_mem_addr", mem_address, a[win]);
      @(negedge clk);
      check_eq("rr_rvalid_win", 32'(get_rvalid(win)), 32'd1);
      check_eq("rr_rvalid_lose", 32'(get_rvalid(1 - win)), 32'd0);
      check_eq("rr_rdata", get_rdata(win), ref_load(longint'(a[win]), int'(s[win])));
      $display("txn contested #%0d -> p%0d rdata=%08h", t, win, get_rdata(win));
    end
    @(posedge clk); #1;
    set_req(0, 1'b0, 32'd0, 1'b0, 32'd0, 3'd0);
    set_req(1, 1'b0, 32'd0, 1'b0, 32'd0, 3'd0);
    mem_rdy = 1'b0;
    @(posedge clk); #1;
  endtask

  // Store stalled in ACCESS, then reset pulled asynchronously.
  task automatic run_reset_mid_access();
    int rv;
    set_req(0, 1'b1, 32'h30, 1'b1, $urandom, 3'd4);
    mem_rdy = 1'b0;
    @(negedge clk);
    check_eq("rst_gnt", 32'(p0_gnt), 32'd1);
    @(posedge clk); #1;
    set_req(0, 1'b0, 32'h30, 1'b1, 32'd0, 3'd4);
    @(negedge clk);
    check_eq("rst_pre_we", 32'(mem_write_enable), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_we_drop", 32'(mem_write_enable), 32'd0);
    check_eq("rst_addr_drop", mem_address, 32'd0);
    check_eq("rst_wdata_drop", mem_write_data, 32'd0);
    ref_last = 1;
    rv = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (p0_rvalid || p1_rvalid) rv++;
      if (c == 1) rst_n = 1'b1;
    end
    check_eq("rst_no_rvalid", 32'(rv), 32'd0);
    @(posedge clk); #1;
    $display("txn reset during ACCESS of store at 00000030");
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [2:0]  size_tbl [8];
    int          port, rdl, sz;
    logic [31:0] addr;
    size_tbl = '{3'd1, 3'd2, 3'd4, 3'd1, 3'd2, 3'd4, 3'd3, 3'd0};

    rst_n = 1'b0; mem_init = 1'b1; mem_rdy = 1'b0;
    set_req(0, 1'b0, 32'd0, 1'b0, 32'd0, 3'd0);
    set_req(1, 1'b0, 32'd0, 1'b0, 32'd0, 3'd0);
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = pattern(i);
    ref_last = 1;

    repeat (3) @(negedge clk);
    check_eq("reset_gnt", {30'd0, p1_gnt, p0_gnt}, 32'd0);
    check_eq("reset_rvalid", {30'd0, p1_rvalid, p0_rvalid}, 32'd0);
    check_eq("reset_err", {30'd0, p1_err, p0_err}, 32'd0);
    check_eq("reset_rdata", p0_rdata | p1_rdata, 32'd0);
    check_eq("reset_mem_en", {30'd0, mem_write_enable, mem_read_enable}, 32'd0);
    check_eq("reset_mem_bus", mem_address | mem_write_data | 32'(mem_xfer_size), 32'd0);
    rst_n = 1'b1; mem_init = 1'b0;
    @(posedge clk); #1;

    run_single(0, 32'h10, 1'b1, 32'hDEADBEEF, 3'd4, 0);
    run_single(0, 32'h10, 1'b0, 32'd0, 3'd4, 0);
    run_single(1, 32'h11, 1'b0, 32'd0, 3'd2, 0);
    run_single(0, 32'h10, 1'b0, 32'd0, 3'd3, 0);
    run_single(1, 32'h3E, 1'b0, 32'd0, 3'd4, 0);
    run_single(0, 32'hFFFFFFFE, 1'b0, 32'd0, 3'd2, 0);
    run_single(0, 32'h20, 1'b0, 32'd0, 3'd4, TIMEOUT + 4);
    run_single(1, 32'h24, 1'b0, 32'd0, 3'd4, 5);
    run_reset_mid_access();
    run_contested(4);

    for (int t = 0; t < 40; t++) begin
      port = $urandom_range(0, 1);
      sz   = int'(size_tbl[$urandom_range(0, 7)]);
      addr = 32'($urandom_range(0, MEM_BYTES + 4));
      if ($urandom_range(0, 2) != 0 && sz != 0) addr = addr & ~32'(sz - 1);
      if ($urandom_range(0, 9) == 0) addr = 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
      rdl = ($urandom_range(0, 9) == 0) ? TIMEOUT + 2 : $urandom_range(0, 3);
      run_single(port, addr, 1'($urandom_range(0, 1)), $urandom, 3'(sz), rdl);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and access sequencer in front of the byte-addressed data memory.
- Port 0 is the core load/store unit; port 1 is the debug/DMA loader.
- Grants round-robin, checks size, alignment and range, and drives one memory transfer at a time.
- Waits on the memory ready signal with a timeout, then returns a registered response pulse to the owner.

Parameters:
- MEM_BYTES, 64, memory size in bytes; accesses with addr + size > MEM_BYTES are errors.
- TIMEOUT, 16, max ACCESS cycles waiting for mem_rdy before an error response; must be >= 1.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- pN_req  input  1  request; held stable until pN_gnt (N = 0, 1).
- pN_addr  input  32  byte address.
- pN_we  input  1  1 = store, 0 = load.
- pN_wdata  input  32  store data, LSB-aligned.
- pN_size  input  3  transfer bytes: 1, 2 or 4.
- pN_gnt  output  1  combinational; request accepted this cycle.
- pN_rvalid  output  1  one-cycle response pulse.
- pN_rdata  output  32  load data, zero-extended; 0 for stores and errors.
- pN_err  output  1  valid with pN_rvalid; 1 = rejected or timed out.
- mem_address  output  32  to memory.
- mem_write_enable  output  1  to memory.
- mem_read_enable  output  1  to memory.
- mem_write_data  output  32  to memory.
- mem_xfer_size  output  3  to memory.
- mem_read_data  input  32  from memory, combinational read.
- mem_rdy  input  1  from memory; access completes on a rising edge where it is 1.

Behaviour:
- Reset (async, immediate): state IDLE, last_grant = 1 (port 0 wins the first tie), timeout counter 0.
- Reset values: all gnt/rvalid/err/rdata 0, all mem_* outputs 0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE arbitration:
  - Only one req high: that port wins.
  - Both high: the port other than last_grant wins.
  - pN_gnt = 1 for the winner in the same cycle; no gnt outside IDLE.
- IDLE capture edge: latch addr/we/wdata/size/owner and set last_grant = owner.
- Legality check at capture:
  - size must be 1, 2 or 4.
  - size 2 needs addr[0] = 0; size 4 needs addr[1:0] = 0.
  - addr + size <= MEM_BYTES, computed in 33 bits so there is no wrap-around.
  - Illegal: go to RESP with err = 1; the memory is never touched.
  - Legal: go to ACCESS, counter cleared.
- ACCESS outputs:
  - mem_address, mem_xfer_size and mem_write_data driven from the latched values.
  - mem_write_enable = we; mem_read_enable = ~we.
  - All mem_* outputs are 0 in every other state.
- ACCESS exits:
  - Edge with mem_rdy = 1: capture mem_read_data, masked to size (1 -> [7:0], 2 -> [15:0]; 0 for stores), err = 0, go to RESP.
  - Otherwise counter increments; if mem_rdy is still 0 when counter = TIMEOUT-1, go to RESP with err = 1, rdata 0.
  - A store may be written repeatedly while stalled; this is harmless because it is the same data.
- RESP: owner's rvalid = 1 with registered rdata/err for exactly one cycle; other port's rvalid = 0; then IDLE.
  - No new grant is issued in RESP.
- Latency, request seen in IDLE at cycle T:
  - gnt at T.
  - ACCESS at T+1.
  - rvalid at T+2 when mem_rdy = 1.
  - Error path: rvalid at T+1.
- Throughput: at most one access per 3 cycles.
- Req deasserted before gnt: no effect.
- Req held after gnt: treated as a new request in the next IDLE.
- Reset asserted mid-ACCESS: enables drop at once and the transfer is abandoned; no response is issued.

Test Plan:
- p0 store addr 0x10, size 4, data 0xDEADBEEF, mem_rdy = 1; then p0 load 0x10 size 4 -> p0_gnt at T, mem_write_enable high at T+1 only, load rvalid at T+2 with rdata 0xDEADBEEF, err 0.
- p0 and p1 request loads simultaneously and hold them -> grants alternate 0, 1, 0, 1 after reset.
  - Each response goes to the correct port only.
  - Byte load of 0xEF at 0x10 returns 0x000000EF.
- Illegal accesses, each -> rvalid at T+1 with err 1, rdata 0, and no mem enable ever asserted:
  - p1 load addr 0x11 size 2.
  - Size 3.
  - Addr 0x3E size 4 (range).
  - Addr 0xFFFFFFFE size 2 (overflow).
- mem_rdy held 0 with TIMEOUT = 16 -> ACCESS lasts 16 cycles, then rvalid with err 1; with mem_rdy rising after 5 cycles -> normal response at cycle 6 of ACCESS, err 0.
- Drop rst_n during ACCESS of a store -> mem_* outputs 0 immediately, no rvalid; after release the first contested grant goes to port 0.
